amber_ex_stage: RTL and testbench
=================================

// Module: amber_ex_stage
// PURPOSE
//  Execute stage of the Amber pipeline (instantiated as stg_ex): takes decoded opcode, operands and
//  register values from ID/RR and produces GP/AR/SR results, memory address and branch redirect,
//  all registered toward MEM/WB. Also handles CSR read/write data routing.
// PARAMETERS
//  none -- widths come from sizes.vh: ADDR 48b (HBIT_ADDR=47), DATA 24b (HBIT_DATA=23),
//  OPC 8b, CC 4b, TGT_GP/SRC_GP 4b, TGT_AR 2b, TGT_SR/SRC_SR 2b, IMMn n bits.
// PORTS
//  iw_clk  in 1  clock; one clock, all state on rising edge
//  iw_rst  in 1  reset, synchronous, active-high
//  iw_pc/ow_pc  in/out 48  instr PC, passed through
//  iw_instr/ow_instr  in/out 24  raw instruction, passed through
//  iw_opc/ow_opc  in/out 8  opcode, passed through
//  iw_sgn_en, iw_imm_en  in 1  sign-extend imm; use imm instead of src_gp_val as operand B
//  iw_imm14_val/12/10/16  in 14/12/10/16  decoded immediates
//  iw_cc  in 4  branch condition code (cc.vh)
//  iw_tgt_gp,iw_tgt_gp_we / ow_*  in/out 4,1  GP dest + write enable
//  iw_tgt_sr,iw_tgt_sr_we / ow_*  in/out 2,1  SR dest + write enable
//  iw_tgt_ar / ow_tgt_ar, ow_tgt_ar_we  in/out 2; out 1  AR dest; we asserted by AR-writing opcodes
//  iw_src_gp, iw_src_ar, iw_src_sr  in 4/2/2  source indices
//  iw_src_gp_val,iw_tgt_gp_val  in 24 ; iw_src_ar_val,iw_tgt_ar_val,iw_src_sr_val,iw_tgt_sr_val  in 48
//  ow_addr  out 48  memory address; ow_result out 24 GP/CSR data; ow_ar_result, ow_sr_result out 48
//  ow_branch_taken out 1, ow_branch_pc out 48  redirect request
//  iw_flush, iw_stall  in 1  pipeline control
// BEHAVIOUR
//  - All outputs registered; latency 1 cycle (inputs sampled at edge N visible after edge N).
//  - Reset: every output 0 (opc=OPC_NOP=0, all we=0, branch_taken=0); internal flags (Z,C,N,V)=0.
//  - Priority rst > flush > stall. Flush: load bubble (as reset, flags kept). Stall: hold all outputs/flags.
//  - opB = imm_en ? (sgn_en ? sext(imm12) : zext(imm12)) : src_gp_val; opA = tgt_gp_val.
//  - MOV: result=opB. ADD/SUB: result=opA+/-opB mod 2^24, update Z,N,C(carry/borrow),V.
//    AND/OR/XOR: bitwise, update Z,N, clear C,V. SHL/SHR: opA shifted by opB[4:0], C=last bit out.
//    CMP: flags as SUB, tgt_gp_we forced 0.
//  - CSRRD: ow_result = iw_src_sr_val[23:0] (upper bits ignored).
//  - CSRWR: ow_result = iw_src_gp_val; ow_sr_result = zext48(iw_src_gp_val); tgt_sr/we passed through.
//  - LD/ST: ow_addr = src_ar_val + sext48(imm12) (zext if !sgn_en); ST: ow_result = src_gp_val.
//  - ADDA (AR arith): ow_ar_result = src_ar_val + sext48(imm14); ow_tgt_ar_we=1.
//  - JCC/BCC: cond from cc vs flags (AL,EQ,NE,LT,GE,...); JCC target = src_ar_val, BCC = pc+sext48(imm16).
//    Taken -> branch_taken=1, branch_pc=target; else 0/0. JSR-style ops set ow_ar_result=pc+1.
//  - Unlisted opcodes: result 0, all we passed through unchanged, no flag change, no branch.
//  - Arithmetic wraps silently; no exceptions.
// STRUCTURE
//  - Shared defines (opcodes.vh, cc.vh, sizes.vh, flags.vh, sr.vh) hold opcode, CC, width, flag-bit, SR index constants.
//  - One natural sub-module: amber_ex_alu (combinational 24b ALU + flag generation); cc evaluation as a function.
// TESTING
//  - Reset 1, release; no stimulus -> all outputs 0, branch_taken=0.
//  - CSRRD src_sr=SR_IDX_PC, src_sr_val=48'h00A5B6 -> ow_result=24'h00A5B6 next cycle; then 48'h00C0DE -> 24'h00C0DE.
//  - CSRWR tgt_sr=SR_IDX_LR, src_gp_val=24'h00EF12 -> ow_result=24'h00EF12, ow_tgt_sr=LR; then 24'h000001 -> 24'h000001.
//  - ADD tgt_gp_val=24'hFFFFFF, imm12=1, imm_en=1 -> ow_result=0, Z=1, C=1; following BCC EQ imm16=4, pc=0x200 -> taken, branch_pc=0x204.
//  - Stall during CSRRD change -> outputs hold previous value; flush -> ow_opc=0, all we=0.

Source files
------------

// File: rtl/amber_ex_stage_pkg.sv
// Shared definitions for the Amber execute stage: widths, opcode / condition
// code / SR index encodings, flag and output record types, and helper functions
// for immediate extension, flag generation and branch condition evaluation.
package amber_ex_stage_pkg;

    localparam int ADDR_W = 48;
    localparam int DATA_W = 24;
    localparam int OPC_W  = 8;
    localparam int CC_W   = 4;

    typedef enum logic [7:0] {
        OPC_NOP   = 8'h00,
        OPC_MOV   = 8'h01,
        OPC_ADD   = 8'h02,
        OPC_SUB   = 8'h03,
        OPC_AND   = 8'h04,
        OPC_OR    = 8'h05,
        OPC_XOR   = 8'h06,
        OPC_SHL   = 8'h07,
        OPC_SHR   = 8'h08,
        OPC_CMP   = 8'h09,
        OPC_CSRRD = 8'h10,
        OPC_CSRWR = 8'h11,
        OPC_LD    = 8'h20,
        OPC_ST    = 8'h21,
        OPC_ADDA  = 8'h22,
        OPC_JCC   = 8'h30,
        OPC_BCC   = 8'h31,
        OPC_JSR   = 8'h32
    } opc_e;

    typedef enum logic [3:0] {
        CC_AL  = 4'h0,
        CC_EQ  = 4'h1,
        CC_NE  = 4'h2,
        CC_LT  = 4'h3,
        CC_GE  = 4'h4,
        CC_LTU = 4'h5,
        CC_GEU = 4'h6,
        CC_MI  = 4'h7,
        CC_PL  = 4'h8,
        CC_VS  = 4'h9,
        CC_VC  = 4'hA,
        CC_GT  = 4'hB,
        CC_LE  = 4'hC,
        CC_NV  = 4'hF
    } cc_e;

    typedef enum logic [1:0] {
        SR_IDX_PC  = 2'd0,
        SR_IDX_LR  = 2'd1,
        SR_IDX_SSP = 2'd2,
        SR_IDX_FL  = 2'd3
    } sr_idx_e;

    // C holds carry for ADD and borrow for SUB/CMP, so LTU == C after a compare.
    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    // Everything the stage hands to MEM/WB, kept as one register record.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [OPC_W-1:0]  opc;
        logic [3:0]        tgt_gp;
        logic              tgt_gp_we;
        logic [1:0]        tgt_sr;
        logic              tgt_sr_we;
        logic [1:0]        tgt_ar;
        logic              tgt_ar_we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] result;
        logic [ADDR_W-1:0] ar_result;
        logic [ADDR_W-1:0] sr_result;
        logic              branch_taken;
        logic [ADDR_W-1:0] branch_pc;
    } ex_out_t;

    function automatic logic [23:0] ext12_24(input logic [11:0] imm, input logic sgn);
        return sgn ? {{12{imm[11]}}, imm} : {12'h000, imm};
    endfunction

    function automatic logic [47:0] ext12_48(input logic [11:0] imm, input logic sgn);
        return sgn ? {{36{imm[11]}}, imm} : {36'h0, imm};
    endfunction

    function automatic logic [47:0] sext14_48(input logic [13:0] imm);
        return {{34{imm[13]}}, imm};
    endfunction

    function automatic logic [47:0] sext16_48(input logic [15:0] imm);
        return {{32{imm[15]}}, imm};
    endfunction

    // Z and N follow the result; C and V are supplied by the operation.
    function automatic flags_t mk_flags(input logic [23:0] res, input logic c, input logic v);
        flags_t f;
        f.z = (res == 24'h000000);
        f.c = c;
        f.n = res[23];
        f.v = v;
        return f;
    endfunction

    function automatic logic cc_eval(input logic [3:0] cc, input flags_t f);
        logic t;
        t = 1'b0;
        case (cc_e'(cc))
            CC_AL:   t = 1'b1;
            CC_EQ:   t = f.z;
            CC_NE:   t = ~f.z;
            CC_LT:   t = f.n ^ f.v;
            CC_GE:   t = ~(f.n ^ f.v);
            CC_LTU:  t = f.c;
            CC_GEU:  t = ~f.c;
            CC_MI:   t = f.n;
            CC_PL:   t = ~f.n;
            CC_VS:   t = f.v;
            CC_VC:   t = ~f.v;
            CC_GT:   t = ~f.z & ~(f.n ^ f.v);
            CC_LE:   t = f.z | (f.n ^ f.v);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/amber_ex_stage_if.sv
// ID/RR -> EX -> MEM/WB bundle for the Amber execute stage.
// iw_* : decoded instruction, operands and pipeline control from ID/RR.
// ow_* : registered results toward MEM/WB.
// master drives iw_* and observes ow_*; slave is the execute stage itself.
interface amber_ex_stage_if;
    import amber_ex_stage_pkg::*;

    logic [ADDR_W-1:0] iw_pc;
    logic [DATA_W-1:0] iw_instr;
    logic [OPC_W-1:0]  iw_opc;
    logic              iw_sgn_en;
    logic              iw_imm_en;
    logic [13:0]       iw_imm14_val;
    logic [11:0]       iw_imm12_val;
    logic [9:0]        iw_imm10_val;
    logic [15:0]       iw_imm16_val;
    logic [CC_W-1:0]   iw_cc;
    logic [3:0]        iw_tgt_gp;
    logic              iw_tgt_gp_we;
    logic [1:0]        iw_tgt_sr;
    logic              iw_tgt_sr_we;
    logic [1:0]        iw_tgt_ar;
    logic [3:0]        iw_src_gp;
    logic [1:0]        iw_src_ar;
    logic [1:0]        iw_src_sr;
    logic [DATA_W-1:0] iw_src_gp_val;
    logic [DATA_W-1:0] iw_tgt_gp_val;
    logic [ADDR_W-1:0] iw_src_ar_val;
    logic [ADDR_W-1:0] iw_tgt_ar_val;
    logic [ADDR_W-1:0] iw_src_sr_val;
    logic [ADDR_W-1:0] iw_tgt_sr_val;
    logic              iw_flush;
    logic              iw_stall;

    logic [ADDR_W-1:0] ow_pc;
    logic [DATA_W-1:0] ow_instr;
    logic [OPC_W-1:0]  ow_opc;
    logic [3:0]        ow_tgt_gp;
    logic              ow_tgt_gp_we;
    logic [1:0]        ow_tgt_sr;
    logic              ow_tgt_sr_we;
    logic [1:0]        ow_tgt_ar;
    logic              ow_tgt_ar_we;
    logic [ADDR_W-1:0] ow_addr;
    logic [DATA_W-1:0] ow_result;
    logic [ADDR_W-1:0] ow_ar_result;
    logic [ADDR_W-1:0] ow_sr_result;
    logic              ow_branch_taken;
    logic [ADDR_W-1:0] ow_branch_pc;

    modport master (
        output iw_pc, iw_instr, iw_opc, iw_sgn_en, iw_imm_en, iw_imm14_val, iw_imm12_val,
               iw_imm10_val, iw_imm16_val, iw_cc, iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr,
               iw_tgt_sr_we, iw_tgt_ar, iw_src_gp, iw_src_ar, iw_src_sr, iw_src_gp_val,
               iw_tgt_gp_val, iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val, iw_tgt_sr_val,
               iw_flush, iw_stall,
        input  ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we,
               ow_tgt_ar, ow_tgt_ar_we, ow_addr, ow_result, ow_ar_result, ow_sr_result,
               ow_branch_taken, ow_branch_pc
    );

    modport slave (
        input  iw_pc, iw_instr, iw_opc, iw_sgn_en, iw_imm_en, iw_imm14_val, iw_imm12_val,
               iw_imm10_val, iw_imm16_val, iw_cc, iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr,
               iw_tgt_sr_we, iw_tgt_ar, iw_src_gp, iw_src_ar, iw_src_sr, iw_src_gp_val,
               iw_tgt_gp_val, iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val, iw_tgt_sr_val,
               iw_flush, iw_stall,
        output ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we,
               ow_tgt_ar, ow_tgt_ar_we, ow_addr, ow_result, ow_ar_result, ow_sr_result,
               ow_branch_taken, ow_branch_pc
    );

endinterface

// File: rtl/amber_ex_stage_alu.sv
// Combinational 24-bit ALU with flag generation for the Amber execute stage.
// Ports: opc (opcode), op_a / op_b (operands), flags_in (current flags),
//        result (ALU data), flags_out (flags_in unless the opcode updates flags).
module amber_ex_alu
    import amber_ex_stage_pkg::*;
(
    input  logic [7:0]  opc,
    input  logic [23:0] op_a,
    input  logic [23:0] op_b,
    input  flags_t      flags_in,
    output logic [23:0] result,
    output flags_t      flags_out
);

    logic [24:0] sum_s;
    logic [24:0] dif_s;
    logic [24:0] shl_s;
    logic [24:0] shr_s;
    logic        add_ovf_s;
    logic        sub_ovf_s;

    // Bit 24 of sum/dif is carry-out / borrow-out.
    assign sum_s = {1'b0, op_a} + {1'b0, op_b};
    assign dif_s = {1'b0, op_a} - {1'b0, op_b};
    // One guard bit on the side the data leaves, so it holds the last bit shifted out
    // (and stays 0 for a zero shift amount).
    assign shl_s = {1'b0, op_a} << op_b[4:0];
    assign shr_s = {op_a, 1'b0} >> op_b[4:0];

    assign add_ovf_s = (op_a[23] == op_b[23]) & (sum_s[23] != op_a[23]);
    assign sub_ovf_s = (op_a[23] != op_b[23]) & (dif_s[23] != op_a[23]);

    // Operation select and flag update.
    always_comb begin
        result    = 24'h000000;
        flags_out = flags_in;
        case (opc_e'(opc))
            OPC_MOV: begin
                result = op_b;
            end
            OPC_ADD: begin
                result    = sum_s[23:0];
                flags_out = mk_flags(sum_s[23:0], sum_s[24], add_ovf_s);
            end
            OPC_SUB, OPC_CMP: begin
                result    = dif_s[23:0];
                flags_out = mk_flags(dif_s[23:0], dif_s[24], sub_ovf_s);
            end
            OPC_AND: begin
                result    = op_a & op_b;
                flags_out = mk_flags(op_a & op_b, 1'b0, 1'b0);
            end
            OPC_OR: begin
                result    = op_a | op_b;
                flags_out = mk_flags(op_a | op_b, 1'b0, 1'b0);
            end
            OPC_XOR: begin
                result    = op_a ^ op_b;
                flags_out = mk_flags(op_a ^ op_b, 1'b0, 1'b0);
            end
            OPC_SHL: begin
                result    = shl_s[23:0];
                flags_out = mk_flags(shl_s[23:0], shl_s[24], 1'b0);
            end
            OPC_SHR: begin
                result    = shr_s[24:1];
                flags_out = mk_flags(shr_s[24:1], shr_s[0], 1'b0);
            end
            default: begin
                result    = 24'h000000;
                flags_out = flags_in;
            end
        endcase
    end

endmodule

// File: rtl/amber_ex_stage.sv
// Amber pipeline execute stage (stg_ex).
// Ports: iw_clk (clock), iw_rst (synchronous active-high reset),
//        ex (amber_ex_stage_if.slave: decoded instruction in, registered results out).
// All outputs are registered with one cycle of latency. Priority rst > flush > stall:
// flush inserts a bubble but keeps the flags, stall freezes outputs and flags.
module amber_ex_stage
    import amber_ex_stage_pkg::*;
(
    input  logic              iw_clk,
    input  logic              iw_rst,
    amber_ex_stage_if.slave   ex
);

    flags_t      flags_r;
    flags_t      alu_flags_s;
    ex_out_t     out_r;
    ex_out_t     nxt_s;
    logic [23:0] op_a_s;
    logic [23:0] op_b_s;
    logic [23:0] alu_result_s;
    logic        cond_s;
    logic        unused_s;

    assign op_a_s = ex.iw_tgt_gp_val;
    assign op_b_s = ex.iw_imm_en ? ext12_24(ex.iw_imm12_val, ex.iw_sgn_en) : ex.iw_src_gp_val;
    // Branches see the flags left by the previous instruction.
    assign cond_s = cc_eval(ex.iw_cc, flags_r);

    // Inputs decoded elsewhere that this stage does not consume.
    assign unused_s = ^{ex.iw_imm10_val, ex.iw_src_gp, ex.iw_src_ar, ex.iw_src_sr,
                        ex.iw_tgt_ar_val, ex.iw_tgt_sr_val, ex.iw_src_sr_val[47:24]};

    amber_ex_alu u_alu (
        .opc       (ex.iw_opc),
        .op_a      (op_a_s),
        .op_b      (op_b_s),
        .flags_in  (flags_r),
        .result    (alu_result_s),
        .flags_out (alu_flags_s)
    );

    // Next-state result record for the instruction currently presented.
    always_comb begin
        nxt_s           = '0;
        nxt_s.pc        = ex.iw_pc;
        nxt_s.instr     = ex.iw_instr;
        nxt_s.opc       = ex.iw_opc;
        nxt_s.tgt_gp    = ex.iw_tgt_gp;
        nxt_s.tgt_gp_we = ex.iw_tgt_gp_we;
        nxt_s.tgt_sr    = ex.iw_tgt_sr;
        nxt_s.tgt_sr_we = ex.iw_tgt_sr_we;
        nxt_s.tgt_ar    = ex.iw_tgt_ar;
        case (opc_e'(ex.iw_opc))
            OPC_MOV, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SHL, OPC_SHR: begin
                nxt_s.result = alu_result_s;
            end
            OPC_CMP: begin
                // Flags only; the difference is never written back.
                nxt_s.tgt_gp_we = 1'b0;
            end
            OPC_CSRRD: begin
                nxt_s.result = ex.iw_src_sr_val[23:0];
            end
            OPC_CSRWR: begin
                nxt_s.result    = ex.iw_src_gp_val;
                nxt_s.sr_result = {24'h000000, ex.iw_src_gp_val};
            end
            OPC_LD: begin
                nxt_s.addr = ex.iw_src_ar_val + ext12_48(ex.iw_imm12_val, ex.iw_sgn_en);
            end
            OPC_ST: begin
                nxt_s.addr   = ex.iw_src_ar_val + ext12_48(ex.iw_imm12_val, ex.iw_sgn_en);
                nxt_s.result = ex.iw_src_gp_val;
            end
            OPC_ADDA: begin
                nxt_s.ar_result = ex.iw_src_ar_val + sext14_48(ex.iw_imm14_val);
                nxt_s.tgt_ar_we = 1'b1;
            end
            OPC_JCC: begin
                nxt_s.branch_taken = cond_s;
                nxt_s.branch_pc    = cond_s ? ex.iw_src_ar_val : 48'h0;
            end
            OPC_BCC: begin
                nxt_s.branch_taken = cond_s;
                nxt_s.branch_pc    = cond_s ? (ex.iw_pc + sext16_48(ex.iw_imm16_val)) : 48'h0;
            end
            OPC_JSR: begin
                // Link address is written regardless of whether the jump is taken.
                nxt_s.branch_taken = cond_s;
                nxt_s.branch_pc    = cond_s ? ex.iw_src_ar_val : 48'h0;
                nxt_s.ar_result    = ex.iw_pc + 48'h1;
                nxt_s.tgt_ar_we    = 1'b1;
            end
            default: begin
                nxt_s.result = 24'h000000;
            end
        endcase
    end

    // Pipeline register and flag state: reset, bubble on flush, hold on stall.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            out_r   <= '0;
            flags_r <= '0;
        end else if (ex.iw_flush) begin
            out_r   <= '0;
            flags_r <= flags_r;
        end else if (!ex.iw_stall) begin
            out_r   <= nxt_s;
            flags_r <= alu_flags_s;
        end else begin
            out_r   <= out_r;
            flags_r <= flags_r;
        end
    end

    assign ex.ow_pc           = out_r.pc;
    assign ex.ow_instr        = out_r.instr;
    assign ex.ow_opc          = out_r.opc;
    assign ex.ow_tgt_gp       = out_r.tgt_gp;
    assign ex.ow_tgt_gp_we    = out_r.tgt_gp_we;
    assign ex.ow_tgt_sr       = out_r.tgt_sr;
    assign ex.ow_tgt_sr_we    = out_r.tgt_sr_we;
    assign ex.ow_tgt_ar       = out_r.tgt_ar;
    assign ex.ow_tgt_ar_we    = out_r.tgt_ar_we;
    assign ex.ow_addr         = out_r.addr;
    assign ex.ow_result       = out_r.result;
    assign ex.ow_ar_result    = out_r.ar_result;
    assign ex.ow_sr_result    = out_r.sr_result;
    assign ex.ow_branch_taken = out_r.branch_taken;
    assign ex.ow_branch_pc    = out_r.branch_pc;

endmodule

// File: tb/tb_amber_ex_stage.sv
// Self-checking bench for amber_ex_stage: a table of vectors with hand-derived
// expectations plus hand-written flush/stall/reset sequences, checked through a
// one-deep scoreboard queue.
module tb_amber_ex_stage;
    import amber_ex_stage_pkg::*;

    typedef struct packed {
        logic [7:0]  opc;
        logic        imm_en;
        logic        sgn_en;
        logic [11:0] imm12;
        logic [13:0] imm14;
        logic [15:0] imm16;
        logic [3:0]  cc;
        logic [3:0]  tgt_gp;
        logic        gp_we;
        logic [1:0]  tgt_sr;
        logic        sr_we;
        logic [1:0]  tgt_ar;
        logic [1:0]  src_sr;
        logic [23:0] src_gp_val;
        logic [23:0] tgt_gp_val;
        logic [47:0] src_ar_val;
        logic [47:0] src_sr_val;
        logic [47:0] pc;
        logic [23:0] instr;
        logic [23:0] e_result;
        logic [47:0] e_addr;
        logic [47:0] e_ar;
        logic [47:0] e_sr;
        logic        e_gp_we;
        logic        e_sr_we;
        logic        e_ar_we;
        logic        e_taken;
        logic [47:0] e_bpc;
    } vec_t;

    logic   clk;
    logic   rst;
    int     total;
    int     bad;
    string  tag;
    vec_t   tbl[$];
    vec_t   sb_q[$];
    vec_t   last_v;

    amber_ex_stage_if bus();

    amber_ex_stage dut (
        .iw_clk (clk),
        .iw_rst (rst),
        .ex     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t blank();
        vec_t v;
        v = '0;
        return v;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %h want %h", tag, name, act, exp);
        end
    endtask

    task automatic compare(input vec_t e);
        check("opc",       48'(bus.ow_opc),          48'(e.opc));
        check("pc",        bus.ow_pc,                e.pc);
        check("instr",     48'(bus.ow_instr),        48'(e.instr));
        check("tgt_gp",    48'(bus.ow_tgt_gp),       48'(e.tgt_gp));
        check("tgt_sr",    48'(bus.ow_tgt_sr),       48'(e.tgt_sr));
        check("tgt_ar",    48'(bus.ow_tgt_ar),       48'(e.tgt_ar));
        check("result",    48'(bus.ow_result),       48'(e.e_result));
        check("addr",      bus.ow_addr,              e.e_addr);
        check("ar_result", bus.ow_ar_result,         e.e_ar);
        check("sr_result", bus.ow_sr_result,         e.e_sr);
        check("gp_we",     48'(bus.ow_tgt_gp_we),    48'(e.e_gp_we));
        check("sr_we",     48'(bus.ow_tgt_sr_we),    48'(e.e_sr_we));
        check("ar_we",     48'(bus.ow_tgt_ar_we),    48'(e.e_ar_we));
        check("taken",     48'(bus.ow_branch_taken), 48'(e.e_taken));
        check("branch_pc", bus.ow_branch_pc,         e.e_bpc);
    endtask

    task automatic drive(input vec_t v);
        bus.iw_opc        = v.opc;
        bus.iw_imm_en     = v.imm_en;
        bus.iw_sgn_en     = v.sgn_en;
        bus.iw_imm12_val  = v.imm12;
        bus.iw_imm14_val  = v.imm14;
        bus.iw_imm16_val  = v.imm16;
        bus.iw_cc         = v.cc;
        bus.iw_tgt_gp     = v.tgt_gp;
        bus.iw_tgt_gp_we  = v.gp_we;
        bus.iw_tgt_sr     = v.tgt_sr;
        bus.iw_tgt_sr_we  = v.sr_we;
        bus.iw_tgt_ar     = v.tgt_ar;
        bus.iw_src_sr     = v.src_sr;
        bus.iw_src_gp_val = v.src_gp_val;
        bus.iw_tgt_gp_val = v.tgt_gp_val;
        bus.iw_src_ar_val = v.src_ar_val;
        bus.iw_src_sr_val = v.src_sr_val;
        bus.iw_pc         = v.pc;
        bus.iw_instr      = v.instr;
    endtask

    // One cycle: drive, predict (rst > flush > stall), clock, compare.
    task automatic step(input vec_t v, input logic fl, input logic st, input logic rs);
        vec_t e;
        drive(v);
        bus.iw_flush = fl;
        bus.iw_stall = st;
        rst          = rs;
        if (rs || fl) e = blank();
        else if (st)  e = last_v;
        else          e = v;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compare(e);
        last_v = e;
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;
        last_v = blank();
        rst = 1'b1;
        bus.iw_flush = 1'b0;
        bus.iw_stall = 1'b0;
        bus.iw_imm10_val  = 10'h000;
        bus.iw_src_gp     = 4'h0;
        bus.iw_src_ar     = 2'h0;
        bus.iw_tgt_ar_val = 48'h0;
        bus.iw_tgt_sr_val = 48'h0;
        drive(blank());

        // ---------------- vector table ----------------
        v = blank(); v.opc = OPC_CSRRD; v.src_sr = SR_IDX_PC; v.src_sr_val = 48'h00A5B6; v.gp_we = 1'b1; v.e_gp_we = 1'b1; v.e_result = 24'h00A5B6; tbl.push_back(v);
        v = blank(); v.opc = OPC_CSRRD; v.src_sr = SR_IDX_PC; v.src_sr_val = 48'h1234_5600_C0DE; v.e_result = 24'h00C0DE; tbl.push_back(v);
        v = blank(); v.opc = OPC_CSRWR; v.tgt_sr = SR_IDX_LR; v.sr_we = 1'b1; v.src_gp_val = 24'h00EF12; v.e_result = 24'h00EF12; v.e_sr = 48'h00EF12; v.e_sr_we = 1'b1; tbl.push_back(v);
        v = blank(); v.opc = OPC_CSRWR; v.tgt_sr = SR_IDX_LR; v.sr_we = 1'b1; v.src_gp_val = 24'h000001; v.e_result = 24'h000001; v.e_sr = 48'h1; v.e_sr_we = 1'b1; tbl.push_back(v);
        v = blank(); v.opc = OPC_ADD; v.tgt_gp_val = 24'hFFFFFF; v.imm_en = 1'b1; v.imm12 = 12'h001; v.gp_we = 1'b1; v.e_gp_we = 1'b1; v.e_result = 24'h000000; tbl.push_back(v);
        v = blank(); v.opc = OPC_BCC; v.cc = CC_EQ; v.imm16 = 16'h0004; v.pc = 48'h200; v.e_taken = 1'b1; v.e_bpc = 48'h204; tbl.push_back(v);
        v = blank(); v.opc = OPC_BCC; v.cc = CC_LTU; v.imm16 = 16'hFFFC; v.pc = 48'h200; v.e_taken = 1'b1; v.e_bpc = 48'h1FC; tbl.push_back(v);
        v = blank(); v.opc = OPC_BCC; v.cc = CC_NE; v.imm16 = 16'h0004; v.pc = 48'h200; tbl.push_back(v);
        v = blank(); v.opc = OPC_SUB; v.tgt_gp_val = 24'h000005; v.src_gp_val = 24'h000007; v.gp_we = 1'b1; v.e_gp_we = 1'b1; v.e_result = 24'hFFFFFE; tbl.push_back(v);
        v = blank(); v.opc = OPC_BCC; v.cc = CC_LT; v.imm16 = 16'h0008; v.pc = 48'h100; v.e_taken = 1'b1; v.e_bpc = 48'h108; tbl.push_back(v);
        v = blank(); v.opc = OPC_ADD; v.tgt_gp_val = 24'h7FFFFF; v.imm_en = 1'b1; v.sgn_en = 1'b1; v.imm12 = 12'h001; v.e_result = 24'h800000; tbl.push_back(v);
        v = blank(); v.opc = OPC_BCC; v.cc = CC_GE; v.imm16 = 16'h0002; v.pc = 48'h300; v.e_taken = 1'b1; v.e_bpc = 48'h302; tbl.push_back(v);
        v = blank(); v.opc = OPC_CMP; v.tgt_gp_val = 24'h00000A; v.src_gp_val = 24'h00000A; v.gp_we = 1'b1; v.e_gp_we = 1'b0; v.e_result = 24'h000000; tbl.push_back(v);
        v = blank(); v.opc = OPC_JCC; v.cc = CC_EQ; v.src_ar_val = 48'h0000_1234_5678; v.e_taken = 1'b1; v.e_bpc = 48'h0000_1234_5678; tbl.push_back(v);
        v = blank(); v.opc = OPC_AND; v.tgt_gp_val = 24'hF0F0F0; v.src_gp_val = 24'h0FF0FF; v.e_result = 24'h00F0F0; tbl.push_back(v);
        v = blank(); v.opc = OPC_JCC; v.cc = CC_LTU; v.src_ar_val = 48'h999; tbl.push_back(v);
        v = blank(); v.opc = OPC_OR; v.tgt_gp_val = 24'h000F00; v.src_gp_val = 24'h0000F0; v.e_result = 24'h000FF0; tbl.push_back(v);
        v = blank(); v.opc = OPC_SHL; v.tgt_gp_val = 24'h800001; v.imm_en = 1'b1; v.imm12 = 12'h001; v.e_result = 24'h000002; tbl.push_back(v);
        v = blank(); v.opc = OPC_BCC; v.cc = CC_LTU; v.imm16 = 16'h0010; v.pc = 48'h10; v.e_taken = 1'b1; v.e_bpc = 48'h20; tbl.push_back(v);
        v = blank(); v.opc = OPC_SHR; v.tgt_gp_val = 24'h000003; v.imm_en = 1'b1; v.imm12 = 12'h002; v.e_result = 24'h000000; tbl.push_back(v);
        v = blank(); v.opc = OPC_LD; v.src_ar_val = 48'h1000; v.imm12 = 12'hFFF; v.sgn_en = 1'b1; v.gp_we = 1'b1; v.e_gp_we = 1'b1; v.e_addr = 48'hFFF; tbl.push_back(v);
        v = blank(); v.opc = OPC_ST; v.src_ar_val = 48'h1000; v.imm12 = 12'hFFF; v.src_gp_val = 24'h0ABCDE; v.e_addr = 48'h1FFF; v.e_result = 24'h0ABCDE; tbl.push_back(v);
        v = blank(); v.opc = OPC_ADDA; v.src_ar_val = 48'h100; v.imm14 = 14'h3FFE; v.e_ar = 48'hFE; v.e_ar_we = 1'b1; tbl.push_back(v);
        v = blank(); v.opc = OPC_JSR; v.cc = CC_AL; v.src_ar_val = 48'h4000; v.pc = 48'h50; v.e_taken = 1'b1; v.e_bpc = 48'h4000; v.e_ar = 48'h51; v.e_ar_we = 1'b1; tbl.push_back(v);
        v = blank(); v.opc = OPC_MOV; v.src_gp_val = 24'h123456; v.gp_we = 1'b1; v.e_gp_we = 1'b1; v.e_result = 24'h123456; tbl.push_back(v);
        v = blank(); v.opc = 8'hEE; v.tgt_gp_val = 24'h111111; v.src_gp_val = 24'h222222; v.gp_we = 1'b1; v.e_gp_we = 1'b1; v.tgt_sr = SR_IDX_SSP; v.sr_we = 1'b1; v.e_sr_we = 1'b1; tbl.push_back(v);
        v = blank(); v.opc = OPC_BCC; v.cc = CC_EQ; v.imm16 = 16'h0001; v.pc = 48'h0; v.e_taken = 1'b1; v.e_bpc = 48'h1; tbl.push_back(v);

        // ---------------- reset state ----------------
        tag = "reset";
        step(blank(), 1'b0, 1'b0, 1'b1);
        step(blank(), 1'b0, 1'b0, 1'b1);
        tag = "idle";
        step(blank(), 1'b0, 1'b0, 1'b0);

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            v.instr  = {8'(i), 16'hC35A};
            v.tgt_gp = 4'(i + 1);
            v.tgt_ar = 2'(i);
            tag = $sformatf("vec%0d", i);
            step(v, 1'b0, 1'b0, 1'b0);
        end

        // ---------------- flush keeps flags ----------------
        tag = "fl_cmp";
        v = blank(); v.opc = OPC_CMP; v.tgt_gp_val = 24'h000005; v.src_gp_val = 24'h000005; v.gp_we = 1'b1;
        step(v, 1'b0, 1'b0, 1'b0);
        tag = "flush";
        v = blank(); v.opc = OPC_CSRWR; v.src_gp_val = 24'h000077; v.gp_we = 1'b1; v.sr_we = 1'b1; v.pc = 48'h44;
        step(v, 1'b1, 1'b0, 1'b0);
        tag = "fl_bcc";
        v = blank(); v.opc = OPC_BCC; v.cc = CC_EQ; v.imm16 = 16'h0004; v.pc = 48'h40; v.e_taken = 1'b1; v.e_bpc = 48'h44;
        step(v, 1'b0, 1'b0, 1'b0);

        // ---------------- stall holds outputs and flags ----------------
        tag = "st_rd";
        v = blank(); v.opc = OPC_CSRRD; v.src_sr_val = 48'h00A5B6; v.e_result = 24'h00A5B6;
        step(v, 1'b0, 1'b0, 1'b0);
        tag = "stall1";
        v = blank(); v.opc = OPC_CSRRD; v.src_sr_val = 48'h00C0DE; v.e_result = 24'h00C0DE;
        step(v, 1'b0, 1'b1, 1'b0);
        tag = "stall2";
        v = blank(); v.opc = OPC_SUB; v.tgt_gp_val = 24'h000009; v.src_gp_val = 24'h000001; v.e_result = 24'h000008;
        step(v, 1'b0, 1'b1, 1'b0);
        tag = "st_bcc";
        v = blank(); v.opc = OPC_BCC; v.cc = CC_EQ; v.imm16 = 16'h0010; v.pc = 48'h80; v.e_taken = 1'b1; v.e_bpc = 48'h90;
        step(v, 1'b0, 1'b0, 1'b0);

        // ---------------- flush beats stall, reset clears flags ----------------
        tag = "fl_st";
        v = blank(); v.opc = OPC_MOV; v.src_gp_val = 24'h00BEEF; v.gp_we = 1'b1; v.pc = 48'h90;
        step(v, 1'b1, 1'b1, 1'b0);
        tag = "rst_mid";
        v = blank(); v.opc = OPC_ADD; v.tgt_gp_val = 24'h000001; v.src_gp_val = 24'h000001; v.gp_we = 1'b1; v.pc = 48'h94;
        step(v, 1'b0, 1'b0, 1'b1);
        tag = "rst_eq";
        v = blank(); v.opc = OPC_BCC; v.cc = CC_EQ; v.imm16 = 16'h0010; v.pc = 48'h80;
        step(v, 1'b0, 1'b0, 1'b0);
        tag = "rst_al";
        v = blank(); v.opc = OPC_BCC; v.cc = CC_AL; v.imm16 = 16'h0010; v.pc = 48'h80; v.e_taken = 1'b1; v.e_bpc = 48'h90;
        step(v, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
